// File: rtl/cis_pkg.sv
// Shared sizing, state encoding and helpers for the CIS correlated-double-sampling accumulator.
package cis_pkg;

    localparam int ADC_WIDTH_DEFAULT = 16;
    localparam int ACC_WIDTH_DEFAULT = 32;
    localparam int SKIP_WIDTH        = 10;
    localparam int COUNT_WIDTH       = 11;
    localparam int TAG_WIDTH         = 16;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        WAIT_BASE,
        WAIT_SIG
    } cds_state_t;

    // A frame always carries one more pair than the repeat count says.
    function automatic logic [COUNT_WIDTH-1:0] pair_target(input logic [SKIP_WIDTH-1:0] skip);
        return COUNT_WIDTH'(skip) + COUNT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/cis_edge_det.sv
// Level-to-pulse converter: compares a level against its one-cycle-delayed registered copy.
module cis_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic rise,
    output logic fall
);

    logic level_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign rise = level & ~level_q;
    assign fall = ~level & level_q;

endmodule

// File: rtl/cis_cds_accumulator.sv
// Accumulates (signal - baseline) ADC pairs over a CIS frame and publishes the sum
// through a valid/ready result port with sticky overrun/sequence error flags.
module cis_cds_accumulator
    import cis_pkg::*;
#(
    parameter int ADC_WIDTH = ADC_WIDTH_DEFAULT,
    parameter int ACC_WIDTH = ACC_WIDTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   integration,
    input  logic [SKIP_WIDTH-1:0]  skip_samples,
    input  logic                   strobe_base,
    input  logic                   strobe_sig,
    input  logic [ADC_WIDTH-1:0]   adc_data,
    output logic [ACC_WIDTH-1:0]   res_data,
    output logic [COUNT_WIDTH-1:0] res_count,
    output logic [TAG_WIDTH-1:0]   res_tag,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic                   err_overrun,
    output logic                   err_sequence
);

    cds_state_t             state;
    logic [ACC_WIDTH-1:0]   acc;
    logic [ADC_WIDTH-1:0]   baseline;
    logic [COUNT_WIDTH-1:0] pair_count;
    logic [COUNT_WIDTH-1:0] target_count;
    logic [TAG_WIDTH-1:0]   frame_tag;

    logic base_rise, base_fall;
    logic sig_rise, sig_fall;
    logic int_rise, int_fall;
    logic unused_falls;

    logic                   waiting;
    logic                   restart;
    logic                   collide;
    logic                   final_pair;
    logic [ACC_WIDTH-1:0]   sample_diff;
    logic [ACC_WIDTH-1:0]   acc_next;
    logic [COUNT_WIDTH-1:0] count_next;

    cis_edge_det u_base_edge (
        .clk   (clk),
        .reset (reset),
        .level (strobe_base),
        .rise  (base_rise),
        .fall  (base_fall)
    );

    cis_edge_det u_sig_edge (
        .clk   (clk),
        .reset (reset),
        .level (strobe_sig),
        .rise  (sig_rise),
        .fall  (sig_fall)
    );

    cis_edge_det u_int_edge (
        .clk   (clk),
        .reset (reset),
        .level (integration),
        .rise  (int_rise),
        .fall  (int_fall)
    );

    assign unused_falls = base_fall | sig_fall;

    // Both operands are zero-extended, so the wrapped difference is the sign-extended delta.
    assign sample_diff = ACC_WIDTH'(adc_data) - ACC_WIDTH'(baseline);
    assign acc_next    = acc + sample_diff;
    assign count_next  = pair_count + COUNT_WIDTH'(1);

    assign waiting    = (state == WAIT_BASE) || (state == WAIT_SIG);
    assign restart    = waiting && int_rise;
    assign collide    = waiting && !int_rise && base_rise && sig_rise;
    assign final_pair = (state == WAIT_SIG) && !int_rise && !base_rise && sig_rise
                        && (count_next >= target_count);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            acc          <= '0;
            baseline     <= '0;
            pair_count   <= '0;
            target_count <= '0;
            err_sequence <= 1'b0;
        end else if (restart) begin
            err_sequence <= 1'b1;
            acc          <= '0;
            pair_count   <= '0;
            state        <= ARMED;
        end else if (collide) begin
            err_sequence <= 1'b1;
            state        <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (int_rise) begin
                        acc        <= '0;
                        pair_count <= '0;
                        state      <= ARMED;
                    end
                end
                ARMED: begin
                    if (int_fall) begin
                        target_count <= pair_target(skip_samples);
                        state        <= WAIT_BASE;
                    end
                end
                WAIT_BASE: begin
                    if (base_rise) begin
                        baseline <= adc_data;
                        state    <= WAIT_SIG;
                    end
                end
                WAIT_SIG: begin
                    if (base_rise) begin
                        baseline <= adc_data;
                    end else if (sig_rise) begin
                        acc        <= acc_next;
                        pair_count <= count_next;
                        state      <= final_pair ? IDLE : WAIT_BASE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A result that finds the port still occupied is dropped but still consumes a tag.
    always_ff @(posedge clk) begin
        if (reset) begin
            res_data    <= '0;
            res_count   <= '0;
            res_tag     <= '0;
            res_valid   <= 1'b0;
            frame_tag   <= '0;
            err_overrun <= 1'b0;
        end else if (final_pair) begin
            frame_tag <= frame_tag + TAG_WIDTH'(1);
            if (res_valid && !res_ready) begin
                err_overrun <= 1'b1;
            end else begin
                res_data  <= acc_next;
                res_count <= count_next;
                res_tag   <= frame_tag;
                res_valid <= 1'b1;
            end
        end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule
